// File: rtl/cell_vector_checker.sv
// Exhaustive-vector functional checker for 1/2-input library cells: drives a/b, waits, samples y.
// Optional CELL_CHK_FIRST_FAIL_EN adds first-mismatch capture (fail_seen/fail_vec/fail_iter).
module cell_vector_checker #(
  parameter int SETTLE_W = 8,
  parameter int ITER_W   = 16,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          func_sel,
  input  logic [SETTLE_W-1:0] settle,
  input  logic [ITER_W-1:0]   iters,
  output logic                a,
  output logic                b,
  input  logic                y,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [CNT_W-1:0]    err_cnt
`ifdef CELL_CHK_FIRST_FAIL_EN
  ,
  output logic                fail_seen,
  output logic [1:0]          fail_vec,
  output logic [ITER_W-1:0]   fail_iter
`endif
);

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, DONE} state_t;

  typedef struct packed {
    logic [2:0]          func;
    logic [SETTLE_W-1:0] settle;
    logic [ITER_W-1:0]   iters;
  } cfg_t;

  state_t              state;
  cfg_t                cfg;
  logic [1:0]          vec;
  logic [ITER_W-1:0]   iter;
  logic [SETTLE_W-1:0] scnt;

  logic              exp_y;
  logic              legal;
  logic              last_pass;
  logic [ITER_W-1:0] n_m1;

  // Expected response is taken from the registered pins, which equal vec during SAMPLE.
  always_comb begin
    exp_y = 1'b0;
    case (cfg.func)
      3'd0:    exp_y = a & b;
      3'd1:    exp_y = a | b;
      3'd2:    exp_y = ~(a & b);
      3'd3:    exp_y = ~(a | b);
      3'd4:    exp_y = ~a;
      default: exp_y = 1'b0;
    endcase
  end

  assign legal     = (cfg.func < 3'd5);
  assign n_m1      = (cfg.iters == '0) ? '0 : cfg.iters - ITER_W'(1);
  assign last_pass = (iter == n_m1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cfg     <= '0;
      vec     <= '0;
      iter    <= '0;
      scnt    <= '0;
      a       <= 1'b0;
      b       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= '0;
`ifdef CELL_CHK_FIRST_FAIL_EN
      fail_seen <= 1'b0;
      fail_vec  <= '0;
      fail_iter <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cfg     <= '{func: func_sel, settle: settle, iters: iters};
            err_cnt <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            pass    <= 1'b0;
            a       <= 1'b0;
            b       <= 1'b0;
            vec     <= '0;
            iter    <= '0;
`ifdef CELL_CHK_FIRST_FAIL_EN
            fail_seen <= 1'b0;
            fail_vec  <= '0;
            fail_iter <= '0;
`endif
            state   <= (func_sel >= 3'd5) ? DONE : APPLY;
          end else if (state == DONE) begin
            // Flags follow DONE entry by one edge so the final err_cnt update is visible.
            busy <= 1'b0;
            done <= 1'b1;
            pass <= legal && (err_cnt == '0);
          end
        end
        APPLY: begin
          a     <= vec[1];
          b     <= vec[0];
          scnt  <= '0;
          state <= (cfg.settle == '0) ? SAMPLE : SETTLE;
        end
        SETTLE: begin
          if (scnt == cfg.settle - SETTLE_W'(1)) state <= SAMPLE;
          else                                   scnt  <= scnt + SETTLE_W'(1);
        end
        SAMPLE: begin
          if ((y != exp_y) && !(&err_cnt)) err_cnt <= err_cnt + CNT_W'(1);
`ifdef CELL_CHK_FIRST_FAIL_EN
          if ((y != exp_y) && !fail_seen) begin
            fail_seen <= 1'b1;
            fail_vec  <= vec;
            fail_iter <= iter;
          end
`endif
          if (vec != 2'd3) begin
            vec   <= vec + 2'd1;
            state <= APPLY;
          end else if (!last_pass) begin
            vec   <= '0;
            iter  <= iter + ITER_W'(1);
            state <= APPLY;
          end else begin
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_vector_checker.sv
// Randomized bench for cell_vector_checker against a truth-table/counting reference model.
// A second instance with CNT_W=2 shares all stimulus to exercise counter saturation.
module tb_cell_vector_checker;
  localparam int SW = 8;
  localparam int IW = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [2:0]    func_sel;
  logic [SW-1:0] settle;
  logic [IW-1:0] iters;
  logic          a, b, y, busy, done, pass;
  logic [CW-1:0] err_cnt;
  logic          a2, b2, busy2, done2, pass2;
  logic [1:0]    err2;
`ifdef CELL_CHK_FIRST_FAIL_EN
  logic          fs, fs2;
  logic [1:0]    fv, fv2;
  logic [IW-1:0] fi, fi2;
`endif

  int checks = 0;
  int errors = 0;
  int run_func = 0;
  int run_mode = 0;
  logic [3:0] run_mask = '0;

  always #5 clk = ~clk;

  cell_vector_checker #(.SETTLE_W(SW), .ITER_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .func_sel(func_sel), .settle(settle), .iters(iters),
    .a(a), .b(b), .y(y), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt)
`ifdef CELL_CHK_FIRST_FAIL_EN
    , .fail_seen(fs), .fail_vec(fv), .fail_iter(fi)
`endif
  );

  cell_vector_checker #(.SETTLE_W(SW), .ITER_W(IW), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .func_sel(func_sel), .settle(settle), .iters(iters),
    .a(a2), .b(b2), .y(y), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2)
`ifdef CELL_CHK_FIRST_FAIL_EN
    , .fail_seen(fs2), .fail_vec(fv2), .fail_iter(fi2)
`endif
  );

  function automatic bit truth(input int f, input bit ta, input bit tb_);
    case (f)
      0:       return ta & tb_;
      1:       return ta | tb_;
      2:       return !(ta & tb_);
      3:       return !(ta | tb_);
      4:       return !ta;
      default: return 1'b0;
    endcase
  endfunction

  // Cell model: 0 ideal, 1 stuck-at-0, 2 stuck-at-1, 3 ideal with per-vector inversions.
  function automatic bit cut_y(input int f, input int m, input logic [3:0] mk,
                               input bit ta, input bit tb_);
    case (m)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return truth(f, ta, tb_) ^ mk[{ta, tb_}];
      default: return truth(f, ta, tb_);
    endcase
  endfunction

  assign y = cut_y(run_func, run_mode, run_mask, a, b);

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic run(input int f, input int s, input int n, input int m, input logic [3:0] mk);
    int nn, per, tot, cyc, exp_cyc, first;
    bit legal;
    legal = (f < 5);
    nn    = (n == 0) ? 1 : n;
    run_func = f; run_mode = m; run_mask = mk;
    per = 0; first = -1;
    for (int v = 0; v < 4; v++)
      if (cut_y(f, m, mk, v[1], v[0]) != truth(f, v[1], v[0])) begin
        per++;
        if (first < 0) first = v;
      end
    tot     = legal ? nn * per : 0;
    exp_cyc = legal ? 4 * nn * (s + 2) + 1 : 1;

    @(negedge clk);
    func_sel = 3'(f); settle = SW'(s); iters = IW'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    func_sel = 3'($urandom); settle = SW'($urandom); iters = IW'($urandom);
    chk("busy_on_accept", int'(busy), 1);
    chk("done_on_accept", int'(done), 0);

    cyc = 0;
    while (!done && cyc < exp_cyc + 10) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == 3);  // mid-run start must be ignored
    end
    start = 1'b0;

    chk("latency", cyc, exp_cyc);
    chk("done", int'(done), 1);
    chk("busy_at_done", int'(busy), 0);
    chk("pass", int'(pass), (legal && tot == 0) ? 1 : 0);
    chk("err_cnt", int'(err_cnt), (tot > 65535) ? 65535 : tot);
    chk("err_cnt_sat2", int'(err2), (tot > 3) ? 3 : tot);
    chk("pass_sat2", int'(pass2), (legal && tot == 0) ? 1 : 0);
    chk("ab_last", int'({a, b}), legal ? 3 : 0);
    chk("ab_last2", int'({a2, b2}), legal ? 3 : 0);
`ifdef CELL_CHK_FIRST_FAIL_EN
    chk("fail_seen", int'(fs), (legal && per > 0) ? 1 : 0);
    chk("fail_vec", int'(fv), (legal && per > 0) ? first : 0);
    chk("fail_iter", int'(fi), 0);
`endif
    @(posedge clk); #1;
    chk("done_hold", int'(done), 1);
    chk("ab_hold", int'({a, b}), legal ? 3 : 0);
  endtask

  task automatic rst_mid_run();
    // NAND with y stuck-at-0: vectors 00 and 01 mismatch before vector 10 settles.
    run_func = 2; run_mode = 1; run_mask = '0;
    @(negedge clk);
    func_sel = 3'd2; settle = SW'(3); iters = IW'(1); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("mid_ab", int'({a, b}), 2);
    chk("mid_err", int'(err_cnt), 2);
    chk("mid_busy", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_ab", int'({a, b}), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err", int'(err_cnt), 0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; func_sel = '0; settle = '0; iters = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ab", int'({a, b}), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_pass", int'(pass), 0);
    chk("reset_err", int'(err_cnt), 0);
`ifdef CELL_CHK_FIRST_FAIL_EN
    chk("reset_fail_seen", int'(fs), 0);
`endif
    rst = 1'b0;

    run(0, 2, 1, 0, 4'h0);  // AND ideal, 17-edge run
    run(2, 1, 3, 2, 4'h0);  // NAND stuck-at-1
    run(1, 1, 4, 1, 4'h0);  // OR stuck-at-0, saturates narrow counter
    run(6, 3, 2, 0, 4'h0);  // reserved function
    run(4, 0, 0, 0, 4'h0);  // INV, iters=0 acts as one pass
    run(3, 1, 2, 1, 4'h0);  // NOR stuck-at-0
    run(0, 0, 1, 3, 4'h6);  // settle=0 with scattered faults
    rst_mid_run();
    run(1, 2, 2, 0, 4'h0);

    for (int i = 0; i < 24; i++)
      run($urandom_range(0, 7), $urandom_range(0, 4), $urandom_range(0, 3),
          $urandom_range(0, 3), 4'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
